// File: rtl/datamem_pkg.sv
// -----------------------------------------------------------------------------
// datamem_pkg
// Shared definitions for the data-memory arbiter slice:
//   - state_t      : sequencer states (IDLE -> ACCESS -> DONE -> IDLE)
//   - DEF_*        : default widths/depth for the memory interface
//   - PORT_CPU/DBG : port-index constants used as grant values
// -----------------------------------------------------------------------------
package datamem_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_MEM_DEPTH = 34;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter. A grant is only taken when the sequencer
// raises `advance`; at that point last_grant is updated so that, under
// continuous contention, the ports alternate strictly.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset (last_grant -> PORT_DBG)
//   req[1:0]     in   request vector, bit i = port i
//   advance      in   sequencer is ready to accept a new transaction
//   grant_valid  out  a grant is taken this cycle
//   grant_idx    out  winning port index (meaningful when grant_valid=1)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import datamem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic last_grant;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_idx = PORT_CPU;
    unique case (req)
      2'b01:   grant_idx = PORT_CPU;
      2'b10:   grant_idx = PORT_DBG;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = PORT_CPU;
    endcase
  end

  assign grant_valid = advance & (|req);

  // Reset to PORT_DBG so the CPU port wins the first contended grant.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_DBG;
    end else if (grant_valid) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// -----------------------------------------------------------------------------
// datamem_arbiter
// Sequencer and two-port round-robin arbiter in front of a combinational,
// write-through data memory. All memory-side outputs come straight from
// registers, so mem_write is a clean one-cycle pulse with stable address and
// data, and there is no combinational path from req* to mem_*.
//
// Transaction: IDLE (grant, register addr/data/we) -> ACCESS (memory access,
// capture dataout) -> DONE (ack pulse with rdata/err) -> IDLE.
//
// Optional feature (macro DATAMEM_ARB_BOUNDS_EN): a winning address
// >= MEM_DEPTH suppresses the write, forces mem_addr to 0 and completes with
// err=1, rdata=0. Without the macro err0/err1 stay 0 and addresses pass through.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req0/we0/addr0/wdata0      port 0 (CPU) request, held until ack0
//   ack0/rdata0/err0           port 0 completion pulse and results
//   req1/we1/addr1/wdata1      port 1 (debug/loader) request
//   ack1/rdata1/err1           port 1 completion pulse and results
//   mem_addr/mem_write/mem_datain  registered drive to the memory
//   mem_dataout                memory read data (write-through)
//   busy                       high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,

  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,

  output logic              busy
);

  state_t state, state_n;

  logic              granted, granted_n;   // port owning the current transaction
  logic              oob, oob_n;           // current transaction is out of range
  logic [ADDR_W-1:0] mem_addr_n;
  logic              mem_write_n;
  logic [DATA_W-1:0] mem_datain_n;
  logic              ack0_n, ack1_n;
  logic [DATA_W-1:0] rdata0_n, rdata1_n;
  logic              err0_n, err1_n;

  logic              grant_valid, grant_idx;
  logic              win_we, win_oob;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({req1, req0}),
    .advance     (state == IDLE),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign win_we    = (grant_idx == PORT_DBG) ? we1    : we0;
  assign win_addr  = (grant_idx == PORT_DBG) ? addr1  : addr0;
  assign win_wdata = (grant_idx == PORT_DBG) ? wdata1 : wdata0;

`ifdef DATAMEM_ARB_BOUNDS_EN
  assign win_oob = (win_addr >= ADDR_W'(MEM_DEPTH));
`else
  // Without the bounds check oob is constantly 0, so the err registers
  // reduce to constant zeros.
  assign win_oob = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_n      = state;
    granted_n    = granted;
    oob_n        = oob;
    mem_addr_n   = mem_addr;     // address/data hold their last value when idle
    mem_datain_n = mem_datain;
    mem_write_n  = 1'b0;         // write only ever lasts the ACCESS cycle
    ack0_n       = 1'b0;
    ack1_n       = 1'b0;
    rdata0_n     = rdata0;
    rdata1_n     = rdata1;
    err0_n       = err0;
    err1_n       = err1;

    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_n      = ACCESS;
          granted_n    = grant_idx;
          oob_n        = win_oob;
          mem_addr_n   = win_oob ? '0 : win_addr;
          mem_datain_n = win_wdata;
          mem_write_n  = win_we & ~win_oob;
        end
      end

      ACCESS: begin
        // Results and ack are registered here so they are presented in DONE.
        state_n = DONE;
        if (granted == PORT_DBG) begin
          rdata1_n = oob ? '0 : mem_dataout;
          err1_n   = oob;
          ack1_n   = 1'b1;
        end else begin
          rdata0_n = oob ? '0 : mem_dataout;
          err0_n   = oob;
          ack0_n   = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      granted    <= PORT_CPU;
      oob        <= 1'b0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_datain <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      state      <= state_n;
      granted    <= granted_n;
      oob        <= oob_n;
      mem_addr   <= mem_addr_n;
      mem_write  <= mem_write_n;
      mem_datain <= mem_datain_n;
      ack0       <= ack0_n;
      ack1       <= ack1_n;
      rdata0     <= rdata0_n;
      rdata1     <= rdata1_n;
      err0       <= err0_n;
      err1       <= err1_n;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_datamem_arbiter
// Directed self-checking bench for datamem_arbiter with a small behavioural
// 34-word write-through memory attached to the mem_* port. Outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_write, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr     = 0;   // cycles with mem_write high
  int n_ack0   = 0;
  int n_ack1   = 0;

  logic [31:0] mem [0:33];

  always #5 clk = ~clk;

  datamem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .ack0        (ack0),
    .rdata0      (rdata0),
    .err0        (err0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .ack1        (ack1),
    .rdata1      (rdata1),
    .err1        (err1),
    .mem_addr    (mem_addr),
    .mem_write   (mem_write),
    .mem_datain  (mem_datain),
    .mem_dataout (mem_dataout),
    .busy        (busy)
  );

  // Behavioural memory: combinational write-through read, write at the edge.
  assign mem_dataout = mem_write ? mem_datain :
                       (mem_addr < 32'd34) ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && mem_addr < 32'd34) mem[mem_addr[5:0]] <= mem_datain;
  end

  always @(negedge clk) begin
    if (mem_write) n_wr++;
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on one port with fixed timing:
  // edge 1 grant (ACCESS), edge 2 ack (DONE), edge 3 back to IDLE.
  task automatic xact(input string tag, input int port, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] ma_exp, input logic mw_exp,
                      input logic [31:0] rd_exp, input logic err_exp);
    int wr_base;
    wr_base = n_wr;
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    tick;
    check({tag, ".busy"},      {31'd0, busy},      32'd1);
    check({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, mw_exp});
    check({tag, ".mem_addr"},  mem_addr,           ma_exp);
    if (we) check({tag, ".mem_datain"}, mem_datain, wdata);
    check({tag, ".early_ack"}, {30'd0, ack1, ack0}, 32'd0);
    tick;
    req0 = 1'b0; req1 = 1'b0;
    check({tag, ".ack"}, {30'd0, ack1, ack0}, (port == 0) ? 32'd1 : 32'd2);
    check({tag, ".rdata"}, (port == 0) ? rdata0 : rdata1, rd_exp);
    check({tag, ".err"}, {31'd0, (port == 0) ? err0 : err1}, {31'd0, err_exp});
    check({tag, ".wr_off"}, {31'd0, mem_write}, 32'd0);
    tick;
    check({tag, ".ack_pulse"}, {30'd0, ack1, ack0}, 32'd0);
    check({tag, ".idle"}, {31'd0, busy}, 32'd0);
    check({tag, ".wr_cycles"}, 32'(n_wr - wr_base), {31'd0, mw_exp});
  endtask

  initial begin
    int ord_port [$];
    int ord_edge [$];
    int ack_base;

    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset then idle
    tick; tick;
    check("rst.ack",        {30'd0, ack1, ack0}, 32'd0);
    check("rst.err",        {30'd0, err1, err0}, 32'd0);
    check("rst.rdata0",     rdata0,     32'd0);
    check("rst.rdata1",     rdata1,     32'd0);
    check("rst.busy",       {31'd0, busy},      32'd0);
    check("rst.mem_write",  {31'd0, mem_write}, 32'd0);
    check("rst.mem_addr",   mem_addr,   32'd0);
    check("rst.mem_datain", mem_datain, 32'd0);
    reset = 1'b0;
    tick; tick;
    check("idle.busy",  {31'd0, busy}, 32'd0);
    check("idle.no_wr", 32'(n_wr), 32'd0);

    // Port 0 store then load, port 1 traffic on the same memory
    xact("p0_st5",  0, 1'b1, 32'd5,  32'hDEADBEEF, 32'd5,  1'b1, 32'hDEADBEEF, 1'b0);
    xact("p0_ld5",  0, 1'b0, 32'd5,  32'h0,        32'd5,  1'b0, 32'hDEADBEEF, 1'b0);
    xact("p1_st33", 1, 1'b1, 32'd33, 32'h12345678, 32'd33, 1'b1, 32'h12345678, 1'b0);
    check("hold.rdata0", rdata0, 32'hDEADBEEF);
    xact("p1_st3",  1, 1'b1, 32'd3,  32'hA5A50003, 32'd3,  1'b1, 32'hA5A50003, 1'b0);
    xact("p1_ld5",  1, 1'b0, 32'd5,  32'h0,        32'd5,  1'b0, 32'hDEADBEEF, 1'b0);
    check("hold.rdata0b", rdata0, 32'hDEADBEEF);

    // Simultaneous requests after reset: 0 first, strict alternation
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd33;
    for (int i = 1; i <= 18; i++) begin
      tick;
      if (ack0) begin
        ord_port.push_back(0); ord_edge.push_back(i);
        check("rr.rdata0", rdata0, 32'hDEADBEEF);
      end
      if (ack1) begin
        ord_port.push_back(1); ord_edge.push_back(i);
        check("rr.rdata1", rdata1, 32'h12345678);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rr.count", 32'(ord_port.size()), 32'd6);
    for (int i = 0; i < 6 && i < ord_port.size(); i++) begin
      check($sformatf("rr.port%0d", i), 32'(ord_port[i]), 32'(i % 2));
      check($sformatf("rr.edge%0d", i), 32'(ord_edge[i]), 32'(2 + 3 * i));
    end
    tick; tick; tick;
    check("rr.idle", {31'd0, busy}, 32'd0);

    // Withdrawal: req1 dropped one cycle after grant
    ack_base = n_ack0 + n_ack1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd3;
    tick;
    check("wd.busy", {31'd0, busy}, 32'd1);
    req1 = 1'b0;
    tick;
    check("wd.ack1",  {30'd0, ack1, ack0}, 32'd2);
    check("wd.rdata", rdata1, 32'hA5A50003);
    repeat (4) tick;
    check("wd.one_ack", 32'(n_ack0 + n_ack1 - ack_base), 32'd1);
    check("wd.idle",    {31'd0, busy}, 32'd0);

    // Reset during ACCESS of a store
    ack_base = n_ack0 + n_ack1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h00000077;
    tick;
    check("ra.wr_high", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    req0 = 1'b0;
    tick;
    check("ra.wr_low", {31'd0, mem_write}, 32'd0);
    check("ra.idle",   {31'd0, busy},      32'd0);
    check("ra.ack",    {30'd0, ack1, ack0}, 32'd0);
    reset = 1'b0;
    tick; tick;
    check("ra.no_ack", 32'(n_ack0 + n_ack1 - ack_base), 32'd0);

    // Out-of-range store
`ifdef DATAMEM_ARB_BOUNDS_EN
    xact("oob_st34", 0, 1'b1, 32'd34, 32'hCAFEF00D, 32'd0,  1'b0, 32'h0,        1'b1);
`else
    xact("oob_st34", 0, 1'b1, 32'd34, 32'hCAFEF00D, 32'd34, 1'b1, 32'hCAFEF00D, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
